counter_seq_ctrl: RTL and testbench

- Command-driven sequencer for a DATA_WIDTH up/down counter.
- Integrates a prescaler that paces count steps. Accepts START/STOP/LOAD/CLEAR commands over a valid/ready port.
- Runs the counter toward a programmed terminal value and signals completion.
- Sits between the board-level control logic (buttons/host regs) and the LED/display count path.

---
 rtl/counter_seq_pkg.sv | 18 +
 rtl/counter_seq_ctrl_tick_gen.sv | 32 +++
 rtl/counter_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_counter_seq_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: command op codes and sequencer state encodings
// shared by counter_seq_ctrl and its testbench.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'b00,
        OP_STOP  = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/counter_seq_ctrl_tick_gen.sv
// tick_gen: prescaler that strobes tick every PRESCALE enabled cycles.
// Ports: clk, rst_n (sync, active-low), en (count enable), tick (strobe).
module tick_gen #(
    parameter int PRESCALE   = 50000000,
    parameter int PRESCALE_W = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] C_ONE = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] C_MAX = PRESCALE_W'(PRESCALE);

    logic [PRESCALE_W-1:0] r_cnt;

    // Strobe is decoded here; the top registers the visible tick output
    // so the count step and tick land on the same edge.
    assign tick = en && (r_cnt == C_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= C_ONE;
        end else if (!en || r_cnt == C_MAX) begin
            r_cnt <= C_ONE;
        end else begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: command-driven up/down counter sequencer with prescaler.
// Ports: clk, rst_n (sync, active-low); cmd_valid/cmd_ready/cmd_op/cmd_dir/
// cmd_data command port; count, running, tick, done, cmd_err outputs.
// Optional: define COUNTER_SEQ_AUTO_RELOAD_EN for periodic (auto-reload) mode.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int PRESCALE   = 50000000,
    parameter int PRESCALE_W = 26
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic                  cmd_dir,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  running,
    output logic                  tick,
    output logic                  done,
    output logic                  cmd_err
);

    state_e                r_state;
    logic [DATA_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0] r_limit;
    logic                  r_dir;
    logic                  r_running;
    logic                  r_tick;
    logic                  r_done;
    logic                  r_err;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
    logic [DATA_WIDTH-1:0] r_reload;
`endif

    logic                  w_acc;
    logic                  w_stop;
    logic                  w_tick;
    logic                  w_en;
    logic [DATA_WIDTH-1:0] w_next;
    op_e                   w_op;

    assign cmd_ready = rst_n;
    assign w_acc     = cmd_valid && cmd_ready;
    assign w_op      = op_e'(cmd_op);
    assign w_stop    = w_acc && (w_op == OP_STOP);
    // Dropping enable on an accepted STOP returns the prescaler to 1
    // on the same edge the FSM leaves RUN.
    assign w_en      = (r_state == ST_RUN) && !w_stop;
    assign w_next    = r_dir ? r_count + DATA_WIDTH'(1)
                             : r_count - DATA_WIDTH'(1);

    tick_gen #(
        .PRESCALE   (PRESCALE),
        .PRESCALE_W (PRESCALE_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_en),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_limit   <= '0;
            r_dir     <= 1'b1;
            r_running <= 1'b0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
            r_reload  <= '0;
`endif
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                ST_RUN: begin
                    if (w_stop) begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end else begin
                        if (w_acc) r_err <= 1'b1;
                        if (w_tick) begin
                            r_tick  <= 1'b1;
                            r_count <= w_next;
                            if (w_next == r_limit) begin
                                r_done <= 1'b1;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
                                r_count <= r_reload;
`else
                                r_state   <= ST_DONE;
                                r_running <= 1'b0;
`endif
                            end
                        end
                    end
                end
                default: begin
                    if (w_acc) begin
                        unique case (w_op)
                            OP_START: begin
                                r_dir     <= cmd_dir;
                                r_limit   <= cmd_data;
                                r_state   <= ST_RUN;
                                r_running <= 1'b1;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
                                r_reload  <= r_count;
`endif
                            end
                            OP_LOAD: begin
                                r_count <= cmd_data;
                                r_state <= ST_IDLE;
                            end
                            OP_CLEAR: begin
                                r_count <= '0;
                                r_state <= ST_IDLE;
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign count   = r_count;
    assign running = r_running;
    assign tick    = r_tick;
    assign done    = r_done;
    assign cmd_err = r_err;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed + random stimulus against a behavioural
// model of the counter sequencer (DATA_WIDTH=4, PRESCALE=4).
module tb_counter_seq_ctrl;
    import counter_seq_pkg::*;

    localparam int DW = 4;
    localparam int PS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic          cmd_dir = 1'b0;
    logic [DW-1:0] cmd_data = '0;
    logic [DW-1:0] count;
    logic          running;
    logic          tick;
    logic          done;
    logic          cmd_err;

    counter_seq_ctrl #(
        .DATA_WIDTH (DW),
        .PRESCALE   (PS),
        .PRESCALE_W (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dir   (cmd_dir),
        .cmd_data  (cmd_data),
        .count     (count),
        .running   (running),
        .tick      (tick),
        .done      (done),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model: cycles spent in RUN since the last step decide
    // when the next step happens; count is plain modular arithmetic.
    int m_count, m_limit, m_reload, m_age;
    bit m_run, m_dir;
    bit e_tick, e_done, e_err;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit v, input int op, input bit d,
                         input int data);
        e_tick = 0;
        e_done = 0;
        e_err  = 0;
        if (!rst_n) begin
            m_count = 0; m_limit = 0; m_reload = 0;
            m_age = 0; m_run = 0; m_dir = 1;
        end else if (m_run) begin
            if (v && op == 1) begin
                m_run = 0;
            end else begin
                if (v) e_err = 1;
                m_age++;
                if (m_age == PS) begin
                    m_age = 0;
                    e_tick = 1;
                    m_count = (m_count + (m_dir ? 1 : (1 << DW) - 1))
                              % (1 << DW);
                    if (m_count == m_limit) begin
                        e_done = 1;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
                        m_count = m_reload;
`else
                        m_run = 0;
`endif
                    end
                end
            end
        end else if (v) begin
            case (op)
                0: begin
                    m_dir = d; m_limit = data; m_reload = m_count;
                    m_run = 1; m_age = 0;
                end
                2: m_count = data;
                3: m_count = 0;
                default: ;
            endcase
        end
    endtask

    task automatic step(input bit v, input int op, input bit d,
                        input int data);
        cmd_valid = v;
        cmd_op    = 2'(op);
        cmd_dir   = d;
        cmd_data  = DW'(data);
        @(posedge clk);
        model(v, op, d, data);
        #1;
        check("count", 32'(count), 32'(m_count));
        check("running", 32'(running), 32'(m_run));
        check("tick", 32'(tick), 32'(e_tick));
        check("done", 32'(done), 32'(e_done));
        check("cmd_err", 32'(cmd_err), 32'(e_err));
        check("cmd_ready", 32'(cmd_ready), 32'(rst_n));
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    int first_done;
    int n_ticks;

    initial begin
        // reset and idle
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(20);

        // count up 3 -> 7
        step(1, 2, 0, 3);
        step(1, 0, 1, 7);
        idle(20);
        check("up_hold", 32'(count), 32'd7);
        check("up_stopped", 32'(running), 32'd0);

        // wrap down 1 -> 0,15,14
        step(1, 2, 0, 1);
        step(1, 0, 0, 14);
        idle(16);
        check("down_hold", 32'(count), 32'd14);

        // illegal LOAD during RUN, then STOP on the tick edge
        step(1, 2, 0, 2);
        step(1, 0, 1, 10);
        idle(2);
        step(1, 2, 0, 9);
        check("mid_err", 32'(cmd_err), 32'd1);
        idle(4);
        step(1, 1, 0, 0);
        check("stop_tick_cnt", 32'(count), 32'd3);
        check("stop_tick_nt", 32'(tick), 32'd0);
        check("stop_tick_run", 32'(running), 32'd0);

        // prescaler restarts from 1: first tick 4 cycles after START
        step(1, 0, 1, 12);
        idle(3);
        check("restart_no_tick", 32'(tick), 32'd0);
        idle(1);
        check("restart_tick", 32'(tick), 32'd1);
        check("restart_cnt", 32'(count), 32'd4);
        step(1, 1, 0, 0);

        // full lap: limit == count
        step(1, 2, 0, 5);
        step(1, 0, 1, 5);
        first_done = 0;
        n_ticks = 0;
        for (int i = 1; i <= 70; i++) begin
            step(0, 0, 0, 0);
            if (tick) n_ticks++;
            if (done && first_done == 0) first_done = i;
        end
        check("lap_cycles", 32'(first_done), 32'd64);
        check("lap_ticks", 32'(n_ticks), 32'd16);

        // reset mid-run
        step(1, 0, 0, 0);
        idle(5);
        rst_n = 1'b0;
        step(0, 0, 0, 0);
        check("rst_cnt", 32'(count), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), $urandom_range(0, 15));
        end
        rst_n = 1'b1;
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
